// File: rtl/wb_stage_commit.sv
// Write-back stage: builds the register-file write from MEM/WB values, owns HI/LO and LLbit,
// counts retired instructions and drives the debug write-back trace.
module wb_stage_commit #(
  parameter int          RETIRE_CNT_W = 32,
  parameter logic [31:0] RESET_PC     = 32'hBFC0_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    eret,
  input  logic                    ll,
  input  logic                    wreg,
  input  logic [4:0]              regdst,
  input  logic [1:0]              result_sel,
  input  logic                    SC_result_sel,
  input  logic [3:0]              load_type,
  input  logic [3:0]              byte_valid,
  input  logic [31:0]             mem_rdata,
  input  logic [31:0]             ALU_result,
  input  logic [31:0]             rf_rdata1_fw,
  input  logic [31:0]             rf_rdata0_fw,
  input  logic [63:0]             MulDiv_result,
  input  logic                    whi,
  input  logic                    wlo,
  input  logic                    hi_i_sel,
  input  logic                    lo_i_sel,
  input  logic [31:0]             PC_plus4,
  input  logic [31:0]             instruction,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [31:0]             rf_wdata,
  output logic [31:0]             hi_o,
  output logic [31:0]             lo_o,
  output logic                    llbit_o,
  output logic [RETIRE_CNT_W-1:0] retire_cnt,
  output logic                    debug_wb_pc_unused_n,
  output logic [31:0]             debug_wb_pc,
  output logic [3:0]              debug_wb_rf_wen,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [31:0]             debug_wb_rf_wdata
);
  localparam logic [3:0] LT_NONE = 4'd0, LT_LB = 4'd1, LT_LBU = 4'd2, LT_LH = 4'd3,
                         LT_LHU = 4'd4, LT_LW = 4'd5, LT_LWL = 4'd6, LT_LWR = 4'd7;

  logic [31:0]             hi_q, lo_q;
  logic                    llbit_q;
  logic [RETIRE_CNT_W-1:0] cnt_q;
  logic [1:0]              off;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;
  logic [31:0]             merged, load_data, wdata;

  assign off     = ALU_result[1:0];
  assign ld_half = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (off)
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      2'd3:    ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
  end

  // LWL/LWR: mem_rdata arrives pre-rotated, so only the per-lane merge is done here
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i +: 8] = byte_valid[i] ? mem_rdata[8*i +: 8] : rf_rdata1_fw[8*i +: 8];
  end

  always_comb begin
    load_data = mem_rdata;
    case (load_type)
      LT_LB:          load_data = {{24{ld_byte[7]}}, ld_byte};
      LT_LBU:         load_data = {24'b0, ld_byte};
      LT_LH:          load_data = {{16{ld_half[15]}}, ld_half};
      LT_LHU:         load_data = {16'b0, ld_half};
      LT_LWL, LT_LWR: load_data = merged;
      LT_NONE, LT_LW: load_data = mem_rdata;
      default:        load_data = mem_rdata;
    endcase
  end

  always_comb begin
    wdata = ALU_result;
    if (SC_result_sel) wdata = {31'b0, llbit_q};
    else begin
      case (result_sel)
        2'b00:   wdata = ALU_result;
        2'b01:   wdata = load_data;
        2'b10:   wdata = PC_plus4 + 32'd4;
        default: wdata = MulDiv_result[31:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q    <= '0;
      lo_q    <= '0;
      llbit_q <= 1'b0;
      cnt_q   <= '0;
    end else if (!stall) begin
      if (whi) hi_q <= hi_i_sel ? rf_rdata0_fw : MulDiv_result[63:32];
      if (wlo) lo_q <= lo_i_sel ? rf_rdata0_fw : MulDiv_result[31:0];
      if (eret)    llbit_q <= 1'b0;
      else if (ll) llbit_q <= 1'b1;
      // encoding 0 (bubble or true NOP) is not counted
      if (instruction != 32'd0) cnt_q <= cnt_q + {{(RETIRE_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign rf_we                = wreg & ~stall & (regdst != 5'd0) & rst_n;
  assign rf_waddr             = regdst;
  assign rf_wdata             = wdata;
  assign hi_o                 = hi_q;
  assign lo_o                 = lo_q;
  assign llbit_o              = llbit_q;
  assign retire_cnt           = cnt_q;
  assign debug_wb_pc_unused_n = 1'b1;
  assign debug_wb_pc          = rst_n ? (PC_plus4 - 32'd4) : RESET_PC;
  assign debug_wb_rf_wen      = {4{rf_we}};
  assign debug_wb_rf_wnum     = regdst;
  assign debug_wb_rf_wdata    = wdata;
endmodule

// File: tb/tb_wb_stage_commit.sv
// Directed bench for wb_stage_commit; a 4-bit retire counter keeps the wrap check short.
module tb_wb_stage_commit;
  localparam int CW = 4;

  logic clk = 1'b0, rst_n, stall, eret, ll, wreg, SC_result_sel, whi, wlo, hi_i_sel, lo_i_sel;
  logic [4:0] regdst;
  logic [1:0] result_sel;
  logic [3:0] load_type, byte_valid;
  logic [31:0] mem_rdata, ALU_result, rf_rdata1_fw, rf_rdata0_fw, PC_plus4, instruction;
  logic [63:0] MulDiv_result;
  logic rf_we, llbit_o, pc_aux;
  logic [4:0] rf_waddr, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, hi_o, lo_o, debug_wb_pc, debug_wb_rf_wdata;
  logic [CW-1:0] retire_cnt;
  logic [3:0] debug_wb_rf_wen;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  wb_stage_commit #(.RETIRE_CNT_W(CW), .RESET_PC(32'hBFC0_0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .eret(eret), .ll(ll), .wreg(wreg),
    .regdst(regdst), .result_sel(result_sel), .SC_result_sel(SC_result_sel),
    .load_type(load_type), .byte_valid(byte_valid), .mem_rdata(mem_rdata),
    .ALU_result(ALU_result), .rf_rdata1_fw(rf_rdata1_fw), .rf_rdata0_fw(rf_rdata0_fw),
    .MulDiv_result(MulDiv_result), .whi(whi), .wlo(wlo), .hi_i_sel(hi_i_sel),
    .lo_i_sel(lo_i_sel), .PC_plus4(PC_plus4), .instruction(instruction),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .hi_o(hi_o), .lo_o(lo_o),
    .llbit_o(llbit_o), .retire_cnt(retire_cnt), .debug_wb_pc_unused_n(pc_aux),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  task automatic idle();
    stall = 0; eret = 0; ll = 0; wreg = 0; SC_result_sel = 0; whi = 0; wlo = 0;
    hi_i_sel = 0; lo_i_sel = 0; regdst = 0; result_sel = 0; load_type = 0; byte_valid = 0;
    mem_rdata = 0; ALU_result = 0; rf_rdata1_fw = 0; rf_rdata0_fw = 0; PC_plus4 = 0;
    instruction = 0; MulDiv_result = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); rst_n = 0; wreg = 1; regdst = 5; whi = 1; wlo = 1; ll = 1; instruction = 1;
    MulDiv_result = 64'h1234_5678_9ABC_DEF0;
    tick(); tick();
    n_cmp++; if (hi_o !== 32'd0) begin n_err++; $display("FAIL reset_hi got %h exp 0", hi_o); end
    n_cmp++; if (lo_o !== 32'd0) begin n_err++; $display("FAIL reset_lo got %h exp 0", lo_o); end
    n_cmp++; if (llbit_o !== 1'b0) begin n_err++; $display("FAIL reset_llbit got %b exp 0", llbit_o); end
    n_cmp++; if (retire_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", retire_cnt); end
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we got %b exp 0", rf_we); end
    n_cmp++; if (debug_wb_rf_wen !== 4'h0) begin n_err++; $display("FAIL reset_dbg_wen got %h exp 0", debug_wb_rf_wen); end
    n_cmp++; if (debug_wb_pc !== 32'hBFC0_0000) begin n_err++; $display("FAIL reset_dbg_pc got %h exp bfc00000", debug_wb_pc); end
    idle(); rst_n = 1;
  endtask

  task automatic test_load();
    idle(); wreg = 1; regdst = 8; result_sel = 2'b01; ALU_result = 32'd3;
    mem_rdata = 32'h80FF_1234; load_type = 4'd1; #1;
    n_cmp++; if (rf_wdata !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb got %h exp ffffff80", rf_wdata); end
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd8) begin n_err++; $display("FAIL lb_we got %b/%0d exp 1/8", rf_we, rf_waddr); end
    load_type = 4'd2; #1;
    n_cmp++; if (rf_wdata !== 32'h0000_0080) begin n_err++; $display("FAIL lbu got %h exp 00000080", rf_wdata); end
    ALU_result = 32'd1; #1;
    n_cmp++; if (rf_wdata !== 32'h0000_0012) begin n_err++; $display("FAIL lbu_off1 got %h exp 00000012", rf_wdata); end
    load_type = 4'd3; ALU_result = 32'd2; mem_rdata = 32'h8001_7FFF; #1;
    n_cmp++; if (rf_wdata !== 32'hFFFF_8001) begin n_err++; $display("FAIL lh got %h exp ffff8001", rf_wdata); end
    load_type = 4'd4; ALU_result = 32'd0; #1;
    n_cmp++; if (rf_wdata !== 32'h0000_7FFF) begin n_err++; $display("FAIL lhu got %h exp 00007fff", rf_wdata); end
    load_type = 4'd6; byte_valid = 4'b1100; mem_rdata = 32'hAABB_CCDD; rf_rdata1_fw = 32'h1122_3344; #1;
    n_cmp++; if (rf_wdata !== 32'hAABB_3344) begin n_err++; $display("FAIL lwl got %h exp aabb3344", rf_wdata); end
    load_type = 4'd7; byte_valid = 4'b0011; #1;
    n_cmp++; if (rf_wdata !== 32'h1122_CCDD) begin n_err++; $display("FAIL lwr got %h exp 1122ccdd", rf_wdata); end
    load_type = 4'd12; #1;
    n_cmp++; if (rf_wdata !== 32'hAABB_CCDD) begin n_err++; $display("FAIL lt_other got %h exp aabbccdd", rf_wdata); end
    idle();
  endtask

  task automatic test_hilo();
    idle(); whi = 1; wlo = 1; MulDiv_result = 64'h0000_0001_FFFF_FFFE; tick();
    n_cmp++; if (hi_o !== 32'd1) begin n_err++; $display("FAIL hi_muldiv got %h exp 1", hi_o); end
    n_cmp++; if (lo_o !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL lo_muldiv got %h exp fffffffe", lo_o); end
    idle(); wlo = 1; lo_i_sel = 1; rf_rdata0_fw = 32'd5; stall = 1; wreg = 1; regdst = 3; tick();
    n_cmp++; if (lo_o !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mtlo_stalled got %h exp fffffffe", lo_o); end
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL stall_rf_we got %b exp 0", rf_we); end
    stall = 0; tick();
    n_cmp++; if (lo_o !== 32'd5 || hi_o !== 32'd1) begin n_err++; $display("FAIL mtlo got %h/%h exp 1/5", hi_o, lo_o); end
    idle(); whi = 1; hi_i_sel = 1; rf_rdata0_fw = 32'hCAFE_0001; tick();
    n_cmp++; if (hi_o !== 32'hCAFE_0001 || lo_o !== 32'd5) begin n_err++; $display("FAIL mthi got %h/%h exp cafe0001/5", hi_o, lo_o); end
    idle();
  endtask

  task automatic test_llbit();
    idle(); ll = 1; tick();
    n_cmp++; if (llbit_o !== 1'b1) begin n_err++; $display("FAIL ll_set got %b exp 1", llbit_o); end
    idle(); SC_result_sel = 1; wreg = 1; regdst = 2; result_sel = 2'b00; ALU_result = 32'h55; #1;
    n_cmp++; if (rf_wdata !== 32'd1) begin n_err++; $display("FAIL sc_ok got %h exp 1", rf_wdata); end
    tick();
    n_cmp++; if (llbit_o !== 1'b1) begin n_err++; $display("FAIL sc_keeps_llbit got %b exp 1", llbit_o); end
    idle(); eret = 1; stall = 1; tick();
    n_cmp++; if (llbit_o !== 1'b1) begin n_err++; $display("FAIL eret_stalled got %b exp 1", llbit_o); end
    stall = 0; ll = 1; tick();
    n_cmp++; if (llbit_o !== 1'b0) begin n_err++; $display("FAIL eret_over_ll got %b exp 0", llbit_o); end
    idle(); SC_result_sel = 1; wreg = 1; regdst = 2; #1;
    n_cmp++; if (rf_wdata !== 32'd0) begin n_err++; $display("FAIL sc_fail got %h exp 0", rf_wdata); end
    idle();
  endtask

  task automatic test_link();
    idle(); wreg = 1; regdst = 0; ALU_result = 32'h77; #1;
    n_cmp++; if (rf_we !== 1'b0 || debug_wb_rf_wen !== 4'h0) begin n_err++; $display("FAIL r0_write got %b/%h exp 0/0", rf_we, debug_wb_rf_wen); end
    regdst = 31; result_sel = 2'b10; PC_plus4 = 32'hBFC0_0010; #1;
    n_cmp++; if (rf_wdata !== 32'hBFC0_0014) begin n_err++; $display("FAIL link got %h exp bfc00014", rf_wdata); end
    n_cmp++; if (debug_wb_pc !== 32'hBFC0_000C) begin n_err++; $display("FAIL dbg_pc got %h exp bfc0000c", debug_wb_pc); end
    n_cmp++; if (debug_wb_rf_wen !== 4'hF || debug_wb_rf_wnum !== 5'd31 || debug_wb_rf_wdata !== 32'hBFC0_0014) begin
      n_err++; $display("FAIL dbg_trace got %h/%0d/%h exp f/31/bfc00014", debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata); end
    PC_plus4 = 32'hFFFF_FFFE; #1;
    n_cmp++; if (rf_wdata !== 32'h0000_0002) begin n_err++; $display("FAIL link_wrap got %h exp 00000002", rf_wdata); end
    result_sel = 2'b11; MulDiv_result = 64'h1111_2222_3333_4444; #1;
    n_cmp++; if (rf_wdata !== 32'h3333_4444) begin n_err++; $display("FAIL sel_muldiv got %h exp 33334444", rf_wdata); end
    result_sel = 2'b00; #1;
    n_cmp++; if (rf_wdata !== 32'h0000_0077) begin n_err++; $display("FAIL sel_alu got %h exp 00000077", rf_wdata); end
    idle();
  endtask

  task automatic test_retire();
    idle(); instruction = 32'h2408_0001;
    for (int i = 0; i < 3; i++) tick();
    instruction = 0; tick();
    instruction = 32'h2408_0001; stall = 1; tick();
    n_cmp++; if (retire_cnt !== 4'd3) begin n_err++; $display("FAIL retire_cnt got %0d exp 3", retire_cnt); end
    stall = 0;
    for (int i = 0; i < 12; i++) tick();
    n_cmp++; if (retire_cnt !== 4'd15) begin n_err++; $display("FAIL retire_max got %0d exp 15", retire_cnt); end
    tick();
    n_cmp++; if (retire_cnt !== 4'd0) begin n_err++; $display("FAIL retire_wrap got %0d exp 0", retire_cnt); end
    idle();
  endtask

  task automatic test_reset_mid();
    idle(); whi = 1; wlo = 1; ll = 1; instruction = 32'h1; MulDiv_result = 64'hDEAD_BEEF_0BAD_F00D; tick();
    n_cmp++; if (hi_o !== 32'hDEAD_BEEF || llbit_o !== 1'b1 || retire_cnt !== 4'd1) begin
      n_err++; $display("FAIL pre_reset got %h/%b/%0d exp deadbeef/1/1", hi_o, llbit_o, retire_cnt); end
    stall = 1; rst_n = 0; tick();
    n_cmp++; if (hi_o !== 32'd0 || lo_o !== 32'd0 || llbit_o !== 1'b0 || retire_cnt !== 4'd0) begin
      n_err++; $display("FAIL reset_in_stall got %h/%h/%b/%0d exp 0/0/0/0", hi_o, lo_o, llbit_o, retire_cnt); end
    idle(); rst_n = 1;
  endtask

  initial begin
    idle(); rst_n = 0;
    test_reset();
    test_load();
    test_hilo();
    test_llbit();
    test_link();
    test_retire();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
